// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - raster-scan pixel stream to registered KxK sliding window
module conv_window_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int KERNEL_SIZE = 3,
    parameter int CONV_SIZE   = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_global_enable,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_window [0:CONV_SIZE-1],
    output logic                  o_valid,
    output logic                  o_frame_done
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST        = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST_VALID = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST        = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST   = RW'(K - 2);
    localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(K - 1);

    typedef enum logic [1:0] {S_FILL, S_STREAM, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_line   [0:K-2][0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_window [0:CONV_SIZE-1];
    logic [DATA_WIDTH-1:0] w_column [0:K-1];
    logic                  r_valid;
    logic                  r_frame_done;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;

    assign o_ready      = i_global_enable && (r_state != S_DONE) && i_reset;
    assign w_accept     = i_valid && o_ready;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    assign o_window     = r_window;
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;

    // New rightmost column: buffered rows oldest first, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            w_column[r] = i_pixel;
        end
        for (int r = 0; r < K - 1; r++) begin
            w_column[r] = r_line[r][r_col];
        end
    end

    // Line buffers shift vertically per column; contents are never reset.
    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            for (int r = 0; r < K - 2; r++) begin
                r_line[r][r_col] <= r_line[r+1][r_col];
            end
            r_line[K-2][r_col] <= i_pixel;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:   if (w_accept && (r_row == ROW_FILL_LAST) && w_col_last) w_state_next = S_STREAM;
            S_STREAM: if (w_accept && w_row_last && w_col_last) w_state_next = S_DONE;
            S_DONE:   if (i_global_enable) w_state_next = S_FILL;
            default:  w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < CONV_SIZE; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_valid      <= w_accept && (r_row >= ROW_FIRST_VALID) && (r_col >= COL_FIRST_VALID);
            r_frame_done <= w_accept && w_row_last && w_col_last;
            if (r_state == S_DONE) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_window[r*K+c] <= r_window[r*K+c+1];
                    end
                    r_window[r*K+K-1] <= w_column[r];
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb/tb_conv_window_buffer.sv - directed bench for conv_window_buffer (5x4 and default 28x28)
module tb_conv_window_buffer;
    localparam int DW = 32;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int CS = 9;
    localparam int NW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          s_reset, s_en, s_valid, s_ready, s_ovalid, s_done;
    logic [DW-1:0] s_pixel;
    logic [DW-1:0] s_window [0:CS-1];
    logic          d_reset, d_en, d_valid, d_ready, d_ovalid, d_done;
    logic [DW-1:0] d_pixel;
    logic [DW-1:0] d_window [0:CS-1];

    conv_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut_s (
        .i_clock(clk), .i_reset(s_reset), .i_global_enable(s_en), .i_valid(s_valid),
        .i_pixel(s_pixel), .o_ready(s_ready), .o_window(s_window), .o_valid(s_ovalid),
        .o_frame_done(s_done));

    conv_window_buffer dut_d (
        .i_clock(clk), .i_reset(d_reset), .i_global_enable(d_en), .i_valid(d_valid),
        .i_pixel(d_pixel), .o_ready(d_ready), .o_window(d_window), .o_valid(d_ovalid),
        .o_frame_done(d_done));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] cap [0:31][0:CS-1];
    bit            cap_done [0:31];
    int            cap_n = 0;
    bit            prev_acc = 1'b0;

    int            d_count = 0;
    int            d_done_count = 0;
    int            d_done_idx = 0;
    logic [DW-1:0] d_first [0:CS-1];

    always @(negedge clk) begin
        if (s_ovalid) begin
            checks++;
            if (!prev_acc) begin
                errors++;
                $display("FAIL valid_without_accept got o_valid=1 required 0");
            end
            if (cap_n < 32) begin
                for (int i = 0; i < CS; i++) cap[cap_n][i] = s_window[i];
                cap_done[cap_n] = s_done;
            end
            cap_n++;
        end else if (s_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid got o_frame_done=1 required 0");
        end
        prev_acc = s_valid && s_ready;
    end

    always @(negedge clk) begin
        if (d_ovalid) begin
            if (d_count == 0) for (int i = 0; i < CS; i++) d_first[i] = d_window[i];
            d_count++;
            if (d_done) begin
                d_done_count++;
                d_done_idx = d_count;
            end
        end
    end

    function automatic logic [DW-1:0] exp_el(input int base, input int n, input int i);
        int r;
        int c;
        r = n / (W - K + 1);
        c = n % (W - K + 1);
        return DW'(base + (r + i / K) * W + c + i % K);
    endfunction

    task automatic drive_px(input logic [DW-1:0] v, input int idle_pct);
        int  budget;
        bit  got;
        while (idle_pct > 0 && $urandom_range(99, 0) < idle_pct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_pixel = v;
        budget  = 0;
        got     = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk); #1;
            budget++;
            if (!got && budget > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout pixel %0d not accepted within 200 cycles", v);
                got = 1'b1;
            end
        end
    endtask

    task automatic drive_range(input int base, input int first, input int last, input int idle_pct);
        for (int p = first; p <= last; p++) drive_px(DW'(base + p), idle_pct);
    endtask

    task automatic settle();
        s_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        s_reset = 1'b0; s_en = 1'b1; s_valid = 1'b1; s_pixel = 32'd77;
        d_reset = 1'b0; d_en = 1'b1; d_valid = 1'b0; d_pixel = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", s_ready); end
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", s_ovalid); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", s_done); end
        for (int i = 0; i < CS; i++) begin
            checks++;
            if (s_window[i] !== '0) begin errors++; $display("FAIL reset_window[%0d] got %0d required 0", i, s_window[i]); end
        end
        @(posedge clk); #1;
        s_reset = 1'b1; d_reset = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] first_w [0:CS-1];
        logic [DW-1:0] last_w  [0:CS-1];
        first_w = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        last_w  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        cap_n = 0;
        drive_range(0, 0, 19, 0);
        settle();
        checks++; if (cap_n !== NW) begin errors++; $display("FAIL stream_count got %0d required %0d", cap_n, NW); end
        for (int i = 0; i < CS; i++) begin
            checks++; if (cap[0][i] !== first_w[i]) begin errors++; $display("FAIL stream_first[%0d] got %0d required %0d", i, cap[0][i], first_w[i]); end
            checks++; if (cap[NW-1][i] !== last_w[i]) begin errors++; $display("FAIL stream_last[%0d] got %0d required %0d", i, cap[NW-1][i], last_w[i]); end
        end
        for (int n = 0; n < NW; n++) begin
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (cap[n][i] !== exp_el(0, n, i)) begin errors++; $display("FAIL stream_win n=%0d i=%0d got %0d required %0d", n, i, cap[n][i], exp_el(0, n, i)); end
            end
            checks++; if (cap_done[n] !== (n == NW - 1)) begin errors++; $display("FAIL stream_done n=%0d got %b required %b", n, cap_done[n], n == NW - 1); end
        end
    endtask

    task automatic test_back_to_back();
        cap_n = 0;
        drive_range(0, 0, 19, 0);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready got %b required 0", s_ready); end
        s_pixel = 32'd100;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_done_ready got %b required 1", s_ready); end
        @(posedge clk); #1;
        drive_range(100, 1, 19, 0);
        settle();
        checks++; if (cap_n !== 2 * NW) begin errors++; $display("FAIL b2b_count got %0d required %0d", cap_n, 2 * NW); end
        for (int n = 0; n < NW; n++) begin
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (cap[n][i] !== exp_el(0, n, i)) begin errors++; $display("FAIL b2b_f0 n=%0d i=%0d got %0d required %0d", n, i, cap[n][i], exp_el(0, n, i)); end
                checks++;
                if (cap[NW+n][i] !== exp_el(100, n, i)) begin errors++; $display("FAIL b2b_f1 n=%0d i=%0d got %0d required %0d", n, i, cap[NW+n][i], exp_el(100, n, i)); end
            end
        end
    endtask

    task automatic test_gaps();
        cap_n = 0;
        drive_range(0, 0, 19, 40);
        settle();
        checks++; if (cap_n !== NW) begin errors++; $display("FAIL gaps_count got %0d required %0d", cap_n, NW); end
        for (int n = 0; n < NW; n++) begin
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (cap[n][i] !== exp_el(0, n, i)) begin errors++; $display("FAIL gaps_win n=%0d i=%0d got %0d required %0d", n, i, cap[n][i], exp_el(0, n, i)); end
            end
            checks++; if (cap_done[n] !== (n == NW - 1)) begin errors++; $display("FAIL gaps_done n=%0d got %b required %b", n, cap_done[n], n == NW - 1); end
        end
    endtask

    task automatic test_freeze();
        cap_n = 0;
        drive_range(0, 0, 13, 0);
        s_en = 1'b0; s_valid = 1'b1; s_pixel = 32'd14;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL freeze_ready got %b required 0", s_ready); end
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL freeze_ready got %b required 0", s_ready); end
            checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL freeze_valid got %b required 0", s_ovalid); end
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (s_window[i] !== exp_el(0, 1, i)) begin errors++; $display("FAIL freeze_hold[%0d] got %0d required %0d", i, s_window[i], exp_el(0, 1, i)); end
            end
        end
        @(posedge clk); #1;
        s_en = 1'b1;
        drive_range(0, 14, 19, 0);
        settle();
        checks++; if (cap_n !== NW) begin errors++; $display("FAIL freeze_count got %0d required %0d", cap_n, NW); end
        for (int n = 0; n < NW; n++) begin
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (cap[n][i] !== exp_el(0, n, i)) begin errors++; $display("FAIL freeze_win n=%0d i=%0d got %0d required %0d", n, i, cap[n][i], exp_el(0, n, i)); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        cap_n = 0;
        drive_range(0, 0, 7, 0);
        s_reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b required 0", s_ready); end
        @(posedge clk); #1;
        s_reset = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b required 0", s_ovalid); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b required 0", s_done); end
        for (int i = 0; i < CS; i++) begin
            checks++;
            if (s_window[i] !== '0) begin errors++; $display("FAIL midrst_window[%0d] got %0d required 0", i, s_window[i]); end
        end
        @(posedge clk); #1;
        cap_n = 0;
        drive_range(0, 0, 19, 0);
        settle();
        checks++; if (cap_n !== NW) begin errors++; $display("FAIL midrst_count got %0d required %0d", cap_n, NW); end
        for (int n = 0; n < NW; n++) begin
            for (int i = 0; i < CS; i++) begin
                checks++;
                if (cap[n][i] !== exp_el(0, n, i)) begin errors++; $display("FAIL midrst_win n=%0d i=%0d got %0d required %0d", n, i, cap[n][i], exp_el(0, n, i)); end
            end
        end
    endtask

    task automatic test_defaults();
        logic [DW-1:0] first_w [0:CS-1];
        int budget;
        bit got;
        first_w = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        for (int p = 0; p < 28 * 28; p++) begin
            d_valid = 1'b1;
            d_pixel = DW'(p);
            got = 1'b0;
            budget = 0;
            while (!got) begin
                @(negedge clk);
                got = d_ready;
                @(posedge clk); #1;
                budget++;
                if (!got && budget > 200) begin
                    checks++; errors++;
                    $display("FAIL defaults_timeout pixel %0d not accepted", p);
                    got = 1'b1;
                end
            end
        end
        d_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (d_count !== 676) begin errors++; $display("FAIL defaults_count got %0d required 676", d_count); end
        checks++; if (d_done_count !== 1) begin errors++; $display("FAIL defaults_done_count got %0d required 1", d_done_count); end
        checks++; if (d_done_idx !== 676) begin errors++; $display("FAIL defaults_done_pos got %0d required 676", d_done_idx); end
        for (int i = 0; i < CS; i++) begin
            checks++;
            if (d_first[i] !== first_w[i]) begin errors++; $display("FAIL defaults_first[%0d] got %0d required %0d", i, d_first[i], first_w[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_gaps();
        test_freeze();
        test_reset_midframe();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
Upstream feeder for the convolution unit. Accepts a raster-scan (row-major) stream of fixed-point pixels, one per accepted cycle. Buffers KERNEL_SIZE-1 previous image rows in line buffers. Emits a registered KERNEL_SIZE x KERNEL_SIZE window, flattened to CONV_SIZE elements, with a valid strobe for every valid-convolution position (no padding, stride 1). The window output drives the convolution unit's input-feature vector directly.

Parameters:
DATA_WIDTH, 32, pixel width in bits (fixed-point, passed through untouched).
IMG_WIDTH, 28, pixels per row; legal range KERNEL_SIZE..1024.
IMG_HEIGHT, 28, rows per frame; legal range KERNEL_SIZE..1024.
KERNEL_SIZE, 3, window side K; legal range 2..5.
CONV_SIZE, KERNEL_SIZE*KERNEL_SIZE, flattened window length. Derived; do not override.

Ports:
i_clock, input, 1, single clock; all logic on the rising edge.
i_reset, input, 1, synchronous active-low reset.
i_global_enable, input, 1, freeze control; low = no accept, state and window held.
i_valid, input, 1, i_pixel is valid this cycle.
i_pixel, input, DATA_WIDTH, next pixel in raster order.
o_ready, output, 1, block accepts a pixel this cycle.
o_window, output, DATA_WIDTH x [0:CONV_SIZE-1], current window; element r*K+c = row r (0 = oldest/top), column c (0 = leftmost).
o_valid, output, 1, o_window holds a new valid window (one-cycle pulse per window).
o_frame_done, output, 1, one-cycle pulse coincident with the last window of the frame.

Behaviour:
- Reset (i_reset=0 at a clock edge): state=FILL; col/row counters=0; o_window all 0; o_valid=0; o_frame_done=0; o_ready=0 during the reset cycle. Line-buffer RAM contents are not reset; stale data is never exposed.
- Accept = i_valid && o_ready. o_ready = i_global_enable && state!=DONE && reset not asserted.
- On accept at position (row, col):
  - Write the pixel into the line-buffer column col.
  - Shift the window one column left.
  - Load rightmost column c=K-1 as: rows 0..K-2 from the line buffers at col (oldest first), row K-1 = i_pixel.
  - Advance col. At col=IMG_WIDTH-1, wrap to 0 and increment row.
- Latency: 1 cycle. o_window and o_valid update on the edge after the accept. o_valid=1 iff the accepted pixel had row>=K-1 and col>=K-1.
- Windows straddling a row wrap (col<K-1) are never flagged valid.
- State machine:
  - FILL: row<K-1. No o_valid. Goes to STREAM when the pixel at (K-2, IMG_WIDTH-1) is accepted.
  - STREAM: windows produced. Goes to DONE when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. o_frame_done pulses with that window's o_valid.
  - DONE: exactly one cycle; o_ready=0; counters cleared; then goes to FILL for the next frame.
- Windows per frame = (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1).
- No accept in a cycle (i_valid=0, or i_global_enable=0): nothing shifts. o_window holds. o_valid and o_frame_done are 0 the next cycle. DONE still advances only when i_global_enable=1.
- Input gaps of any length are legal. The output sequence is independent of gap pattern.
- There is no downstream backpressure; the consumer must take every o_valid window.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0). No window mixes pre- and post-reset data.
- Counter widths: clog2(IMG_WIDTH) and clog2(IMG_HEIGHT). No arithmetic is applied to pixel data.

Test Plan:
- K=3, IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*5+col, i_valid=1 every cycle. First o_valid comes 1 cycle after pixel 12 is accepted, with o_window={0,1,2,5,6,7,10,11,12}. Exactly 6 windows. Last window {7,8,9,12,13,14,17,18,19} has o_frame_done=1.
- Same frame: after the last accept, o_ready=0 for exactly one cycle (DONE), then 1. A back-to-back second frame of values +100 gives first window {100,101,102,105,106,107,110,111,112}.
- Same frame with pseudo-random i_valid gaps (~40% idle): identical ordered window sequence. o_valid never asserted without a preceding accept.
- i_global_enable=0 for 5 cycles mid-STREAM with i_valid=1: o_ready=0, no accepts, o_window held, o_valid=0. Resuming gives a sequence identical to the first scenario.
- Accept 8 pixels, pulse i_reset=0 for one cycle, then stream a full frame: all outputs 0 after reset, and the windows match the first scenario exactly.
- Defaults (28x28, K=3), ramp input: 676 windows, o_frame_done only on the last. Window (row 0, col 0) = {0,1,2,28,29,30,56,57,58}.
